fpu_issue_ctrl: RTL and testbench
=================================

// Module: fpu_issue_ctrl
// PURPOSE
//  Sequences one FPU instruction at a time between the core and the variable-latency FPU execution unit.
//  Resolves dynamic rounding mode against the frm CSR field and rejects illegal encodings.
//  Drives fpu_active, fpu_complete, S_flag and illegal_instr into the FPU CSR block.
//  Arbitrates core fflags/frm/fcsr accesses so they never overlap an in-flight operation.
// PARAMETERS
//  CNT_W    4   width of the execution watchdog counter
//  TIMEOUT  12  EXEC cycles without ex_done before abort; must be < 2**CNT_W
//  OP_MAX   19  highest legal instr_op encoding; larger values are illegal
// PORTS
//  clk            in   1  clock; all state updates on posedge
//  rst            in   1  synchronous, active-high reset
//  instr_valid    in   1  core presents an FPU instruction
//  instr_ready    out  1  controller accepts instruction (transfer = valid & ready)
//  instr_op       in   5  FPU operation code
//  instr_rm       in   3  instruction rm field; 3'b111 = dynamic
//  csr_frm        in   3  current frm value from the FPU CSR block
//  csr_req        in   1  core requests an FPU CSR read/write (single cycle)
//  csr_gnt        out  1  CSR access performed this cycle
//  ex_start       out  1  one-cycle start pulse to the execution unit
//  ex_op          out  5  captured op, stable while fpu_active
//  ex_rm          out  3  resolved rounding mode, stable while fpu_active
//  ex_done        in   1  execution unit result/flags valid
//  ex_flags       in   5  NV,DZ,OF,UF,NX from execution unit
//  ex_abort       out  1  one-cycle pulse on watchdog expiry
//  wb_valid       out  1  result ready for core writeback
//  wb_ready       in   1  core accepts writeback
//  fpu_active     out  1  operation in EXEC or WB
//  fpu_complete   out  1  one-cycle pulse: flags to be accrued this edge
//  s_flag         out  5  flags to accrue; valid only with fpu_complete, else 0
//  illegal_instr  out  1  one-cycle pulse for a rejected instruction
// BEHAVIOUR
//  States: IDLE, EXEC, WB, ILL. Reset (any cycle, incl. mid-op) -> IDLE.
//   Clears counter, captured op/rm/flags and arbitration pointer; pending op is dropped with no fpu_complete.
//  Reset/idle values: all outputs 0, except instr_ready and csr_gnt, which follow arbitration in IDLE.
//   While rst=1, instr_ready=0 and csr_gnt=0.
//  Arbitration (IDLE only; outside IDLE instr_ready=0, csr_gnt=0):
//   - Only one requester: that one is served.
//   - Both requesting: round-robin 1-bit pointer; after reset CSR wins first.
//   - Pointer flips to the other requester after each grant.
//   - instr_ready=1 in IDLE unless CSR is granted that cycle.
//  Accept (IDLE, instr_valid & instr_ready):
//   - eff_rm = (instr_rm==3'b111) ? csr_frm : instr_rm.
//   - Illegal if eff_rm in {101,110,111} or instr_op > OP_MAX -> ILL.
//   - Otherwise capture op/eff_rm -> EXEC, counter=0.
//  ILL: illegal_instr=1 for exactly one cycle, no ex_start, no fpu_complete; next state IDLE.
//  EXEC:
//   - fpu_active=1; ex_start=1 only in first EXEC cycle; ex_done ignored in that cycle.
//   - On ex_done: latch ex_flags -> WB.
//   - Else counter++; at counter==TIMEOUT, ex_abort=1 for one cycle -> IDLE, no flags accrued.
//  WB:
//   - wb_valid=1 held until wb_ready; fpu_active=1.
//   - On wb_valid & wb_ready (same cycle): fpu_complete=1, s_flag=latched flags -> IDLE.
//   - fpu_complete combinational on that handshake.
//  Latency: accept T, ex_start T+1, earliest ex_done T+2, wb_valid T+3, earliest next accept T+4.
//  A CSR access granted the cycle after fpu_complete sees accrued flags (CSR blocking during EXEC/WB guarantees ordering).
//  ex_op/ex_rm hold captured values in EXEC/WB, 0 otherwise; frm changes mid-op do not affect ex_rm.
// TESTING
//  - rm=000, op=3, ex_done 3 cyc after ex_start, flags=00001, wb_ready=1
//    -> ex_rm=000, fpu_complete 1 cyc, s_flag=00001.
//  - rm=111, csr_frm=010 -> ex_rm=010.
//  - rm=111, csr_frm=101 -> illegal_instr pulse, no ex_start, back to IDLE next cycle.
//  - op=OP_MAX+1 -> illegal_instr pulse.
//  - instr_valid & csr_req held 4 cycles in IDLE from reset
//    -> csr_gnt first, then instr accepted; csr_gnt=0 throughout EXEC/WB.
//  - No ex_done -> ex_abort exactly TIMEOUT cycles after ex_start cycle, fpu_complete never asserted.
//  - wb_ready low 5 cycles -> wb_valid held, fpu_complete only on handshake.
//  - rst asserted in EXEC -> next cycle IDLE, all outputs 0, no fpu_complete.

Source files
------------

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: sequences one FPU instruction at a time into a
// variable-latency execution unit, resolves dynamic rounding, rejects
// illegal encodings and keeps FPU CSR accesses off in-flight operations.
module fpu_issue_ctrl #(
   parameter int CNT_W   = 4,
   parameter int TIMEOUT = 12,
   parameter int OP_MAX  = 19
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       instr_valid,
   output logic       instr_ready,
   input  logic [4:0] instr_op,
   input  logic [2:0] instr_rm,
   input  logic [2:0] csr_frm,
   input  logic       csr_req,
   output logic       csr_gnt,
   output logic       ex_start,
   output logic [4:0] ex_op,
   output logic [2:0] ex_rm,
   input  logic       ex_done,
   input  logic [4:0] ex_flags,
   output logic       ex_abort,
   output logic       wb_valid,
   input  logic       wb_ready,
   output logic       fpu_active,
   output logic       fpu_complete,
   output logic [4:0] s_flag,
   output logic       illegal_instr
);

   localparam logic [CNT_W-1:0] TIMEOUT_L = CNT_W'(TIMEOUT);
   localparam logic [4:0]       OP_MAX_L  = 5'(OP_MAX);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_WB   = 2'd2,
      S_ILL  = 2'd3
   } state_t;

   state_t           state_r, state_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic [4:0]       op_r, op_s;
   logic [2:0]       rm_r, rm_s;
   logic [4:0]       flags_r, flags_s;
   logic             ptr_r, ptr_s;     // 0: CSR has priority, 1: instruction has priority
   logic             first_r, first_s; // first EXEC cycle (start pulse, ex_done ignored)
   logic [2:0]       eff_rm_s;
   logic             illegal_s;

   // Resolve the dynamic rounding mode and classify the presented encoding.
   always_comb begin
      eff_rm_s  = (instr_rm == 3'b111) ? csr_frm : instr_rm;
      illegal_s = (eff_rm_s > 3'b100) || (instr_op > OP_MAX_L);
   end

   // Next-state, arbitration and output decode.
   always_comb begin
      state_s       = state_r;
      cnt_s         = cnt_r;
      op_s          = op_r;
      rm_s          = rm_r;
      flags_s       = flags_r;
      ptr_s         = ptr_r;
      first_s       = first_r;
      instr_ready   = 1'b0;
      csr_gnt       = 1'b0;
      ex_start      = 1'b0;
      ex_op         = 5'd0;
      ex_rm         = 3'd0;
      ex_abort      = 1'b0;
      wb_valid      = 1'b0;
      fpu_active    = 1'b0;
      fpu_complete  = 1'b0;
      s_flag        = 5'd0;
      illegal_instr = 1'b0;
      case (state_r)
         S_IDLE: begin
            csr_gnt     = csr_req & (~instr_valid | ~ptr_r);
            instr_ready = ~csr_gnt;
            if (csr_gnt) begin
               ptr_s = 1'b1;
            end else if (instr_valid) begin
               ptr_s = 1'b0;
               if (illegal_s) begin
                  state_s = S_ILL;
               end else begin
                  op_s    = instr_op;
                  rm_s    = eff_rm_s;
                  cnt_s   = '0;
                  first_s = 1'b1;
                  state_s = S_EXEC;
               end
            end else begin
               ptr_s = ptr_r;
            end
         end
         S_EXEC: begin
            fpu_active = 1'b1;
            ex_op      = op_r;
            ex_rm      = rm_r;
            ex_start   = first_r;
            if (first_r) begin
               first_s = 1'b0;
               cnt_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (ex_done) begin
               flags_s = ex_flags;
               state_s = S_WB;
            end else if (cnt_r == TIMEOUT_L) begin
               ex_abort = 1'b1;
               state_s  = S_IDLE;
            end else begin
               cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         S_WB: begin
            fpu_active = 1'b1;
            wb_valid   = 1'b1;
            ex_op      = op_r;
            ex_rm      = rm_r;
            if (wb_ready) begin
               fpu_complete = 1'b1;
               s_flag       = flags_r;
               state_s      = S_IDLE;
            end else begin
               state_s = S_WB;
            end
         end
         S_ILL: begin
            illegal_instr = 1'b1;
            state_s       = S_IDLE;
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase
      // A pending operation is dropped silently while reset is applied.
      if (rst) begin
         instr_ready   = 1'b0;
         csr_gnt       = 1'b0;
         ex_start      = 1'b0;
         ex_op         = 5'd0;
         ex_rm         = 3'd0;
         ex_abort      = 1'b0;
         wb_valid      = 1'b0;
         fpu_active    = 1'b0;
         fpu_complete  = 1'b0;
         s_flag        = 5'd0;
         illegal_instr = 1'b0;
      end else begin
         s_flag = s_flag;
      end
   end

   // State, watchdog counter, captured operation and arbitration pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= S_IDLE;
         cnt_r   <= '0;
         op_r    <= 5'd0;
         rm_r    <= 3'd0;
         flags_r <= 5'd0;
         ptr_r   <= 1'b0;
         first_r <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         op_r    <= op_s;
         rm_r    <= rm_s;
         flags_r <= flags_s;
         ptr_r   <= ptr_s;
         first_r <= first_s;
      end
   end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl: a scoreboard of expected
// completions/illegal/abort events plus a small execution-unit model.
module tb_fpu_issue_ctrl;

   localparam int TIMEOUT = 12;
   localparam logic [2:0] K_DONE  = 3'b100;
   localparam logic [2:0] K_ILL   = 3'b010;
   localparam logic [2:0] K_ABORT = 3'b001;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       instr_valid = 1'b0, instr_ready;
   logic [4:0] instr_op = 5'd0;
   logic [2:0] instr_rm = 3'd0, csr_frm = 3'd0;
   logic       csr_req = 1'b0, csr_gnt;
   logic       ex_start, ex_abort, wb_valid, fpu_active, fpu_complete, illegal_instr;
   logic [4:0] ex_op, s_flag;
   logic [2:0] ex_rm;
   logic       ex_done = 1'b0, wb_ready = 1'b1;
   logic [4:0] ex_flags = 5'd0;

   fpu_issue_ctrl #(.CNT_W(4), .TIMEOUT(TIMEOUT), .OP_MAX(19)) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_op(instr_op), .instr_rm(instr_rm), .csr_frm(csr_frm), .csr_req(csr_req),
      .csr_gnt(csr_gnt), .ex_start(ex_start), .ex_op(ex_op), .ex_rm(ex_rm),
      .ex_done(ex_done), .ex_flags(ex_flags), .ex_abort(ex_abort), .wb_valid(wb_valid),
      .wb_ready(wb_ready), .fpu_active(fpu_active), .fpu_complete(fpu_complete),
      .s_flag(s_flag), .illegal_instr(illegal_instr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] kind;
      logic [4:0] op;
      logic [2:0] rm;
      logic [4:0] flags;
      int         d;
      int         wbd;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Execution-unit model controls
   int         done_delay = 0, wb_delay = 0, rem = 0, wbc = 0;
   logic [4:0] flags_val = 5'd0;
   logic       armed = 1'b0, start_seen = 1'b0, wb_seen = 1'b0;

   // Monitor state
   int   cyc = 0, wbn = 0;
   logic prev_ill = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   function automatic logic [20:0] all_outs();
      return {instr_ready, csr_gnt, ex_start, ex_op, ex_rm, ex_abort, wb_valid,
              fpu_active, fpu_complete, s_flag, illegal_instr};
   endfunction

   // Execution unit: ex_done d cycles after ex_start, wb_ready low wb_delay cycles of wb_valid
   always @(posedge clk) begin
      #1;
      if (rst) begin
         armed = 1'b0; ex_done = 1'b0; wb_ready = 1'b1; start_seen = 1'b0; wbc = 0;
      end else begin
         if (start_seen) begin
            start_seen = 1'b0; rem = done_delay; armed = (done_delay > 0); wbc = wb_delay;
         end
         ex_done  = 1'b0;
         ex_flags = ~flags_val;
         if (armed) begin
            rem--;
            if (rem == 0) begin
               ex_done = 1'b1; ex_flags = flags_val; armed = 1'b0;
            end
         end
         if (wb_seen && wbc > 0) wbc--;
         wb_ready = (wbc == 0);
      end
   end

   // Scoreboard monitor, sampled away from the active edge
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (ex_start) begin
            start_seen = 1'b1; cyc = 0; wbn = 0;
            if (q.size() == 0) check("start_unexpected", 32'd1, 32'd0);
            else begin
               check("start_not_ill", 32'(q[0].kind == K_ILL), 32'd0);
               check("start_op", 32'(ex_op), 32'(q[0].op));
               check("start_rm", 32'(ex_rm), 32'(q[0].rm));
            end
         end else cyc++;
         wb_seen = wb_valid;
         if (wb_valid) wbn++;
         if (fpu_active) check("busy_no_arb", 32'({csr_gnt, instr_ready}), 32'd0);
         if (prev_ill) check("ill_to_idle", 32'(instr_ready | csr_gnt), 32'd1);
         prev_ill = illegal_instr;
         if (fpu_complete | illegal_instr | ex_abort) begin
            if (q.size() == 0) check("event_unexpected", 32'd1, 32'd0);
            else begin
               e = q.pop_front();
               check("event_kind", 32'({fpu_complete, illegal_instr, ex_abort}), 32'(e.kind));
               if (e.kind == K_DONE) begin
                  check("s_flag", 32'(s_flag), 32'(e.flags));
                  check("done_latency", 32'(cyc), 32'(e.d + 1 + e.wbd));
                  check("wb_hold", 32'(wbn), 32'(e.wbd + 1));
                  check("wb_op_rm", 32'({ex_op, ex_rm}), 32'({e.op, e.rm}));
               end else if (e.kind == K_ABORT) begin
                  check("abort_cycles", 32'(cyc), 32'(TIMEOUT));
                  check("abort_rm", 32'(ex_rm), 32'(e.rm));
               end else begin
                  check("ill_outs", 32'({ex_op, ex_rm, ex_start, s_flag}), 32'd0);
               end
            end
         end else if (s_flag != 5'd0) begin
            check("s_flag_idle", 32'(s_flag), 32'd0);
         end
      end
   end

   task automatic push_exp(input logic [4:0] op, input logic [2:0] rm, input logic [2:0] frm,
                           input int d, input int wbd, input logic [4:0] fl);
      exp_t e;
      logic [2:0] eff;
      eff = (rm == 3'b111) ? frm : rm;
      e.op = op; e.rm = eff; e.flags = fl; e.d = d; e.wbd = wbd;
      if (eff > 3'd4 || op > 5'd19) e.kind = K_ILL;
      else if (d == 0)              e.kind = K_ABORT;
      else                          e.kind = K_DONE;
      q.push_back(e);
      done_delay = d; wb_delay = wbd; flags_val = fl;
   endtask

   task automatic issue(input logic [4:0] op, input logic [2:0] rm, input logic [2:0] frm,
                        input int d, input int wbd, input logic [4:0] fl);
      logic acc;
      push_exp(op, rm, frm, d, wbd, fl);
      instr_op = op; instr_rm = rm; csr_frm = frm; instr_valid = 1'b1;
      acc = 1'b0;
      for (int i = 0; i < 20 && !acc; i++) begin
         @(negedge clk);
         acc = instr_ready;
         @(posedge clk); #1;
      end
      instr_valid = 1'b0;
      csr_frm = ~frm;
      check("accept", 32'(acc), 32'd1);
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
      check("drain", 32'(q.size()), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      // Reset with both requesters active: everything must stay quiet
      instr_valid = 1'b1; csr_req = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_outs", 32'(all_outs()), 32'd0);
      push_exp(5'd4, 3'd0, 3'd0, 2, 0, 5'b00100);
      instr_op = 5'd4; instr_rm = 3'd0;
      @(posedge clk); #1;
      rst = 1'b0;
      // Arbitration from reset: CSR first, then instruction, then blocked
      @(negedge clk);
      check("arb0_csr", 32'({csr_gnt, instr_ready}), 32'b10);
      @(negedge clk);
      check("arb1_instr", 32'({csr_gnt, instr_ready}), 32'b01);
      @(negedge clk);
      check("arb2_busy", 32'({csr_gnt, instr_ready}), 32'b00);
      @(negedge clk);
      check("arb3_busy", 32'({csr_gnt, instr_ready}), 32'b00);
      @(posedge clk); #1;
      instr_valid = 1'b0; csr_req = 1'b0;
      drain();
      @(negedge clk);
      check("idle_ready", 32'({csr_gnt, instr_ready}), 32'b01);
      @(posedge clk); #1;
      csr_req = 1'b1;
      @(negedge clk);
      check("csr_only", 32'({csr_gnt, instr_ready}), 32'b10);
      @(posedge clk); #1;
      csr_req = 1'b0;

      issue(5'd3,  3'b000, 3'b000, 3, 0, 5'b00001); drain();
      issue(5'd5,  3'b111, 3'b010, 2, 0, 5'b10100); drain();
      issue(5'd1,  3'b111, 3'b101, 2, 0, 5'b00000); drain();
      issue(5'd20, 3'b000, 3'b000, 2, 0, 5'b00000); drain();
      issue(5'd19, 3'b100, 3'b000, 1, 0, 5'b11111); drain();
      issue(5'd8,  3'b110, 3'b000, 1, 0, 5'b00000); drain();
      issue(5'd7,  3'b000, 3'b000, 0, 0, 5'b00000); drain();
      issue(5'd2,  3'b001, 3'b000, 4, 5, 5'b01010); drain();

      for (int k = 0; k < 8; k++) begin
         issue(5'($urandom_range(0, 21)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
               int'($urandom_range(1, 5)), int'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
         drain();
      end

      // Reset in the middle of EXEC: operation dropped, no completion
      issue(5'd6, 3'b011, 3'b000, 0, 0, 5'b00000);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("rst_mid_outs", 32'(all_outs()), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      q.delete();
      @(negedge clk);
      check("post_rst_outs", 32'(all_outs()), 32'h100000);
      repeat (20) @(posedge clk);
      #1;
      issue(5'd9, 3'b010, 3'b000, 2, 1, 5'b00110); drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
